// File: rtl/int_wb_arbiter_pkg.sv
// Shared types and configuration for the integer writeback arbiter.
// The intWbArbCfg group holds the default requester, port and starvation
// settings used by the core build.
package int_wb_arbiter_pkg;

  // intWbArbCfg
  localparam int INT_WB_REQ_NUM      = 4;
  localparam int INT_WB_PORT_NUM     = 2;
  localparam int INT_WB_STARVE_LIMIT = 7;

  localparam int IPRD_W = 7;
  localparam int ROB_W  = 6;
  localparam int XLEN   = 32;

  // Regfile write info
  typedef struct packed {
    logic              rd_wen;
    logic [IPRD_W-1:0] iprd_idx;
    logic [XLEN-1:0]   result;
  } valWBInfo_t;

  // ROB completion info
  typedef struct packed {
    logic [ROB_W-1:0] rob_idx;
    logic [XLEN-1:0]  result;
  } commWBInfo_t;

endpackage

// File: rtl/int_wb_arbiter_if.sv
// Bundle between the FU writeback sources (master) and the arbiter (slave).
//
// Handshake: a requester holds i_req_vld[i] with stable payload; the transfer
// happens in a cycle where i_req_vld[i] and o_req_rdy[i] are both high. Ready
// is a grant computed in the same cycle and never reflects downstream state.
// o_wb_vld[k] is a one-cycle strobe; payload is meaningful only while it is 1.
interface int_wb_arbiter_if
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = INT_WB_REQ_NUM,
  parameter int NUM_PORT = INT_WB_PORT_NUM
);
  logic        [NUM_REQ-1:0]  i_req_vld;
  logic        [NUM_REQ-1:0]  o_req_rdy;
  valWBInfo_t  [NUM_REQ-1:0]  i_req_val;
  commWBInfo_t [NUM_REQ-1:0]  i_req_comm;
  logic        [NUM_PORT-1:0] o_wb_vld;
  valWBInfo_t  [NUM_PORT-1:0] o_wb_val;
  commWBInfo_t [NUM_PORT-1:0] o_wb_comm;

  modport master (
    output i_req_vld, i_req_val, i_req_comm,
    input  o_req_rdy, o_wb_vld, o_wb_val, o_wb_comm
  );

  modport slave (
    input  i_req_vld, i_req_val, i_req_comm,
    output o_req_rdy, o_wb_vld, o_wb_val, o_wb_comm
  );
endinterface

// File: rtl/int_wb_arbiter_rr_multi_grant.sv
// rr_multi_grant: combinational N-request, M-grant rotating priority encoder.
// Forced requesters go first (lowest index first), then the rotation starting
// at ptr. The k-th winner in that order is reported on sel[k].
module int_wb_arbiter_rr_multi_grant #(
  parameter int N  = 4,
  parameter int M  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [PW-1:0]       ptr,
  input  logic [N-1:0]        force_vec,
  output logic [N-1:0]        grant,
  output logic [M-1:0][N-1:0] sel
);
  localparam int CW = $clog2(M + 1);

  logic [CW-1:0] rank [N];
  logic [CW-1:0] cnt;
  logic [PW-1:0] idx;
  int            idx_i;

  // Walk forced requesters, then the rotation, granting until M ports are used
  always_comb begin
    grant = '0;
    cnt   = '0;
    idx   = '0;
    idx_i = 0;
    for (int i = 0; i < N; i++) rank[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && force_vec[i] && (cnt < CW'(M))) begin
        grant[i] = 1'b1;
        rank[i]  = cnt;
        cnt      = cnt + CW'(1);
      end
    end
    for (int o = 0; o < N; o++) begin
      idx_i = (int'(ptr) + o) % N;
      idx   = idx_i[PW-1:0];
      if (req[idx] && !grant[idx] && (cnt < CW'(M))) begin
        grant[idx] = 1'b1;
        rank[idx]  = cnt;
        cnt        = cnt + CW'(1);
      end
    end
  end

  // Expand ranks into a one-hot requester select per port
  always_comb begin
    sel = '0;
    for (int p = 0; p < M; p++) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i] && (rank[i] == CW'(p))) sel[p][i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: shares NUM_PORT regfile/ROB writeback ports among
// NUM_REQ FU sources with round-robin priority and a starvation override,
// registering winners into per-port slots (1-cycle latency).
// Optional build macro INT_WB_ARB_PERF_EN adds conflict/starvation counters.
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = INT_WB_REQ_NUM,
  parameter int NUM_PORT     = INT_WB_PORT_NUM,
  parameter int STARVE_LIMIT = INT_WB_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  int_wb_arbiter_if.slave   wb
`ifdef INT_WB_ARB_PERF_EN
  ,
  output logic [31:0]       o_perf_conflict,
  output logic [31:0]       o_perf_starve
`endif
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]                     rr_ptr;
  logic [PW-1:0]                     rr_ptr_nxt;
  logic [SW-1:0]                     starve_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]                force_vec;
  logic [NUM_REQ-1:0]                grant;
  logic [NUM_PORT-1:0][NUM_REQ-1:0]  sel;
  logic [NUM_PORT-1:0]               fill;
  valWBInfo_t  [NUM_PORT-1:0]        val_nxt;
  commWBInfo_t [NUM_PORT-1:0]        comm_nxt;
  int                                rot_i;
  int                                nxt_i;

  // Requesters that have lost STARVE_LIMIT cycles in a row jump the rotation
  always_comb begin
    force_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) force_vec[i] = (starve_cnt[i] == SW'(STARVE_LIMIT));
  end

  int_wb_arbiter_rr_multi_grant #(
    .N (NUM_REQ),
    .M (NUM_PORT)
  ) u_rr_multi_grant (
    .req       (wb.i_req_vld),
    .ptr       (rr_ptr),
    .force_vec (force_vec),
    .grant     (grant),
    .sel       (sel)
  );

  // Ready is the grant itself, held low while reset is asserted
  assign wb.o_req_rdy = grant & {NUM_REQ{rst}};

  // Next pointer: one past the granted requester furthest along the rotation
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    rot_i      = 0;
    nxt_i      = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      rot_i = (int'(rr_ptr) + o) % NUM_REQ;
      if (grant[rot_i[PW-1:0]]) begin
        nxt_i      = (rot_i + 1) % NUM_REQ;
        rr_ptr_nxt = nxt_i[PW-1:0];
      end
    end
  end

  // Pointer and starvation counters; a flush clears counters but keeps the pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      if (!i_flush) rr_ptr <= rr_ptr_nxt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_flush || !wb.i_req_vld[i] || grant[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != SW'(STARVE_LIMIT)) begin
          starve_cnt[i] <= starve_cnt[i] + SW'(1);
        end
      end
    end
  end

  // Route each port's selected requester payload
  always_comb begin
    fill     = '0;
    val_nxt  = '0;
    comm_nxt = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      fill[p] = |sel[p];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel[p][i]) begin
          val_nxt[p]  = wb.i_req_val[i];
          comm_nxt[p] = wb.i_req_comm[i];
        end
      end
    end
  end

  // Output slots: strobe for one cycle per grant, payload held when idle or flushed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb.o_wb_vld  <= '0;
      wb.o_wb_val  <= '0;
      wb.o_wb_comm <= '0;
    end else begin
      for (int p = 0; p < NUM_PORT; p++) begin
        wb.o_wb_vld[p] <= fill[p] && !i_flush;
        if (fill[p] && !i_flush) begin
          wb.o_wb_val[p]  <= val_nxt[p];
          wb.o_wb_comm[p] <= comm_nxt[p];
        end
      end
    end
  end

`ifdef INT_WB_ARB_PERF_EN
  int n_vld_i;
  int n_forced_i;

  // Count valid requesters and grants won through the starvation override
  always_comb begin
    n_vld_i    = 0;
    n_forced_i = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_vld_i    = n_vld_i + int'(wb.i_req_vld[i]);
      n_forced_i = n_forced_i + int'(grant[i] && force_vec[i]);
    end
  end

  // Wrapping performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_perf_conflict <= '0;
      o_perf_starve   <= '0;
    end else begin
      if (n_vld_i > NUM_PORT) o_perf_conflict <= o_perf_conflict + 32'd1;
      o_perf_starve <= o_perf_starve + 32'(n_forced_i);
    end
  end
`endif

endmodule
